// File: rtl/ihp_ram_ctrl_if.sv
// Request/response bus for ihp_ram_ctrl.
// The master issues requests and the slave (the RAM controller) returns read data.
interface ihp_ram_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_W/8-1:0]   req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  init_done;

    modport master (
        output req_valid, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/ihp_ram_ctrl.sv
// Single-port byte-masked RAM controller with optional zero-fill after reset.
// Define IHP_RAM_RDREG_EN to add an output register stage (read latency 2 instead of 1).
module ihp_ram_ctrl #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input logic          clk,
    input logic          rst,
    ihp_ram_ctrl_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   init_cnt_q, init_cnt_d;   // extra MSB marks "all addresses written"
    logic              ce, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              ready;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ce         = 1'b0;
        we         = 1'b0;
        ready      = 1'b0;
        addr       = bus.req_addr;
        wdata      = bus.req_wdata;
        be         = bus.req_be;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q[ADDR_W]) begin
                    state_d = ST_RUN;
                end else begin
                    ce         = 1'b1;
                    we         = 1'b1;
                    addr       = init_cnt_q[ADDR_W-1:0];
                    wdata      = '0;
                    be         = '1;
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
                ce    = bus.req_valid;
                we    = |bus.req_be;
            end
            default: state_d = ST_INIT;
        endcase
        // The array and the handshake are held idle for the whole reset pulse.
        if (rst) begin
            ce    = 1'b0;
            ready = 1'b0;
        end
    end

    // NOTE: the storage array has no reset; only its control and output registers do.
    always_ff @(posedge clk) begin
        if (ce && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read data register holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= ce && !we;
            if (ce && !we) rd_data_q <= mem[addr];
        end
    end

`ifdef IHP_RAM_RDREG_EN
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) out_data_q <= rd_data_q;
        end
    end

    assign bus.rsp_valid = out_valid_q;
    assign bus.rsp_rdata = out_data_q;
`else
    assign bus.rsp_valid = rd_valid_q;
    assign bus.rsp_rdata = rd_data_q;
`endif

    assign bus.req_ready = ready;
    assign bus.init_done = (state_q == ST_RUN) && !rst;
endmodule

// File: tb/tb_ihp_ram_ctrl.sv
// Self-checking bench for ihp_ram_ctrl: a word-level reference model is compared against the DUT
// every cycle, plus directed vectors with hand-computed expected values.
module tb_ihp_ram_ctrl;
`ifdef IHP_RAM_RDREG_EN
    localparam int N_LAT = 2;
`else
    localparam int N_LAT = 1;
`endif
    localparam int INIT_CYC = 1025;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ihp_ram_ctrl_if #(.DATA_W(64), .ADDR_W(10)) bus ();
    ihp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(4))  bus2 ();

    ihp_ram_ctrl #(.DATA_W(64), .ADDR_W(10), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ihp_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .INIT_ZERO(1'b0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    logic [63:0] mmem [1024];
    rsp_t        pend [$];
    int          since_rel = 0;     // clock edges since reset release
    logic [63:0] last_rdata = '0;

    always @(posedge clk) begin
        logic rdy;
        if (rst) begin
            since_rel = 0;
            pend.delete();
        end else begin
            rdy = (since_rel >= INIT_CYC);
            since_rel++;
            if (since_rel == INIT_CYC)
                for (int i = 0; i < 1024; i++) mmem[i] = '0;
            if (rdy && bus.req_valid) begin
                if (bus.req_be == '0) begin
                    pend.push_back('{due: since_rel + N_LAT - 1, data: mmem[bus.req_addr]});
                end else begin
                    for (int b = 0; b < 8; b++)
                        if (bus.req_be[b]) mmem[bus.req_addr][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        if (rst) begin
            last_rdata = '0;
            check("rst_req_ready", bus.req_ready, 1'b0);
            check("rst_rsp_valid", bus.rsp_valid, 1'b0);
            check("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
            check("rst_init_done", bus.init_done, 1'b0);
        end else begin
            exp_v = (pend.size() > 0) && (pend[0].due == since_rel);
            if (exp_v) begin
                last_rdata = pend[0].data;
                void'(pend.pop_front());
            end
            check("cyc_rsp_valid", bus.rsp_valid, exp_v);
            check("cyc_rsp_rdata", bus.rsp_rdata, last_rdata);
            check("cyc_req_ready", bus.req_ready, since_rel >= INIT_CYC);
            check("cyc_init_done", bus.init_done, since_rel >= INIT_CYC);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input logic [7:0] be, input logic [9:0] a, input logic [63:0] d);
        @(posedge clk); #2;
        bus.req_valid = 1'b1;
        bus.req_be    = be;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic idle();
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, output logic [63:0] d, output int lat);
        req(8'h00, a, 64'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        d   = '0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.rsp_valid) begin
                lat = i;
                d   = bus.rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                check({tag, "_dut2_ready_first"}, bus2.req_ready, 1'b1);
                check({tag, "_dut2_done_first"},  bus2.init_done, 1'b1);
            end
            if (bus.init_done) begin
                n = i;
                break;
            end
        end
        check({tag, "_init_done_cycle"}, n, 1025);
    endtask

    task automatic read_expect(input string name, input logic [9:0] a, input logic [63:0] exp);
        logic [63:0] d;
        int          lat;
        do_read(a, d, lat);
        check({name, "_data"}, d, exp);
        check({name, "_latency"}, lat, N_LAT);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int not_ready;
        int rsp_seen;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_be     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus2.req_valid = 1'b0;
        bus2.req_be    = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",     bus.req_ready, 1'b0);
        check("reset_init_done", bus.init_done, 1'b0);
        check("reset_dut2_ready", bus2.req_ready, 1'b0);
        check("reset_dut2_done",  bus2.init_done, 1'b0);
        #1 rst = 1'b0;
        wait_init("boot");

        read_expect("zero_a0",    10'd0,    64'h0);
        read_expect("zero_a512",  10'd512,  64'h0);
        read_expect("zero_a1023", 10'd1023, 64'h0);

        req(8'hFF, 10'd5, 64'h0123456789ABCDEF);
        req(8'h0F, 10'd5, 64'hFFFFFFFFFFFFFFFF);
        idle();
        read_expect("mask_a5", 10'd5, 64'h01234567FFFFFFFF);

        req(8'hFF, 10'd20, 64'h1111111111111111);
        req(8'hF0, 10'd20, 64'h2222222222222222);
        req(8'h81, 10'd20, 64'h3333333333333333);
        read_expect("mask_a20", 10'd20, 64'h3322222211111133);

        req(8'hFF, 10'd7, 64'hAAAAAAAAAAAAAAAA);
        read_expect("raw_a7", 10'd7, 64'hAAAAAAAAAAAAAAAA);

        // Alternating write/read stream, each read hitting the address just written.
        not_ready = 0;
        for (int i = 0; i < 32; i++) begin
            req(8'hFF >> (i % 4), 10'(100 + i), {32'(i) ^ 32'hC0FFEE00, ~32'(i)});
            if (!bus.req_ready) not_ready++;
            req(8'h00, 10'(100 + i), 64'h0);
            if (!bus.req_ready) not_ready++;
        end
        idle();
        check("stream_not_ready_cycles", not_ready, 0);
        repeat (4) @(posedge clk);

        // Reset the cycle after a read is accepted: that response must never appear.
        req(8'h00, 10'd5, 64'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        rsp_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) rsp_seen++;
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) rsp_seen++;
            if (i == 0) check("dut2_ready_after_rst2", bus2.req_ready, 1'b1);
        end
        check("dropped_read_no_rsp", rsp_seen, 0);
        check("mid_init_not_done", bus.init_done, 1'b0);

        // Reset again with the init counter at 300; zero-fill must restart from 0.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_init("restart");

        read_expect("refill_a5",   10'd5,   64'h0);
        read_expect("refill_a100", 10'd100, 64'h0);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
